// File: rtl/lift_ctrl_n.sv
`default_nettype none
// ============================================================================
// Module   : lift_ctrl_n
// Brief    : N-floor collective (SCAN) lift controller with door dwell and
//            emergency stop; LIFT_PARK_EN adds idle park-to-ground.
// Revision : 1.0
// ============================================================================
module lift_ctrl_n #(
    parameter int FLOORS      = 4,
    parameter int MOVE_CYCLES = 4,
    parameter int DOOR_CYCLES = 8,
    parameter int PARK_CYCLES = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [FLOORS-1:0]         call_req,
    input  logic                      door_block,
    input  logic                      estop,
    output logic [$clog2(FLOORS)-1:0] floor,
    output logic [FLOORS-1:0]         pending,
    output logic                      motor_on,
    output logic                      dir_up,
    output logic                      door_open,
    output logic                      arrive,
    output logic                      fault
);
    localparam int FW = $clog2(FLOORS);
    localparam int MW = $clog2(MOVE_CYCLES + 1);
    localparam int DW = $clog2(DOOR_CYCLES + 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] MOVE_UP = 3'd1;
    localparam logic [2:0] MOVE_DN = 3'd2;
    localparam logic [2:0] DOOR    = 3'd3;
    localparam logic [2:0] ESTOP   = 3'd4;

    if (FLOORS < 2 || FLOORS > 16 || MOVE_CYCLES < 1 || DOOR_CYCLES < 1 || PARK_CYCLES < 1) begin : g_param_check
        $error("lift_ctrl_n: parameter out of range");
    end

    function automatic logic any_above(input logic [FLOORS-1:0] p, input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (i > int'(f) && p[i]) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic any_below(input logic [FLOORS-1:0] p, input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (i < int'(f) && p[i]) r = 1'b1;
        end
        return r;
    endfunction

    logic [2:0]        state, state_n;
    logic [MW-1:0]     move_cnt, move_n;
    logic [DW-1:0]     dwell, dwell_n;
    logic [FW-1:0]     floor_n, next_floor;
    logic [FLOORS-1:0] pending_n, clr, absorb;
    logic              motor_n, dir_n, door_n, arrive_n, fault_n;
    logic              req_up, req_dn, ahead, park_hold;

    assign req_up     = any_above(pending, floor);
    assign req_dn     = any_below(pending, floor);
    assign next_floor = (state == MOVE_UP) ? floor + FW'(1) : floor - FW'(1);
    assign ahead      = (state == MOVE_UP) ? any_above(pending, next_floor)
                                           : any_below(pending, next_floor);

`ifdef LIFT_PARK_EN
    localparam int PW = $clog2(PARK_CYCLES + 1);
    logic [PW-1:0] park_cnt, park_n;
    logic          parking, park_start;

    // A parking trip only continues while nobody has asked for service.
    assign park_hold = parking && (pending == '0);
`else
    assign park_hold = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        floor_n  = floor;
        move_n   = move_cnt;
        dwell_n  = dwell;
        motor_n  = motor_on;
        dir_n    = dir_up;
        door_n   = door_open;
        arrive_n = 1'b0;
        fault_n  = fault;
        clr      = '0;
        absorb   = '0;
`ifdef LIFT_PARK_EN
        park_n     = '0;
        park_start = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pending[floor]) begin
                    state_n  = DOOR;
                    clr      = FLOORS'(1) << floor;
                    door_n   = 1'b1;
                    arrive_n = 1'b1;
                    dwell_n  = DW'(DOOR_CYCLES);
                end else if ((dir_up && req_up) || (!dir_up && !req_dn && req_up)) begin
                    state_n = MOVE_UP;
                    dir_n   = 1'b1;
                    motor_n = 1'b1;
                    move_n  = '0;
                end else if (req_dn) begin
                    state_n = MOVE_DN;
                    dir_n   = 1'b0;
                    motor_n = 1'b1;
                    move_n  = '0;
                end else begin
`ifdef LIFT_PARK_EN
                    if (floor != '0) begin
                        if (park_cnt == PW'(PARK_CYCLES - 1)) begin
                            state_n    = MOVE_DN;
                            dir_n      = 1'b0;
                            motor_n    = 1'b1;
                            move_n     = '0;
                            park_start = 1'b1;
                        end else begin
                            park_n = park_cnt + PW'(1);
                        end
                    end
`endif
                end
            end
            MOVE_UP, MOVE_DN: begin
                if (move_cnt == MW'(MOVE_CYCLES - 1)) begin
                    floor_n = next_floor;
                    move_n  = '0;
                    if (park_hold) begin
                        if (next_floor == '0) begin
                            state_n = IDLE;
                            motor_n = 1'b0;
                        end
                    end else if (pending[next_floor]) begin
                        state_n  = DOOR;
                        clr      = FLOORS'(1) << next_floor;
                        motor_n  = 1'b0;
                        door_n   = 1'b1;
                        arrive_n = 1'b1;
                        dwell_n  = DW'(DOOR_CYCLES);
                    end else if (!ahead) begin
                        state_n = IDLE;
                        motor_n = 1'b0;
                    end
                end else begin
                    move_n = move_cnt + MW'(1);
                end
            end
            DOOR: begin
                // Calls at the open floor are served by the open door itself.
                absorb = FLOORS'(1) << floor;
                if (door_block || call_req[floor]) begin
                    dwell_n = DW'(DOOR_CYCLES);
                end else if (dwell <= DW'(1)) begin
                    state_n = IDLE;
                    door_n  = 1'b0;
                    dwell_n = '0;
                end else begin
                    dwell_n = dwell - DW'(1);
                end
            end
            ESTOP: begin
                if (!estop) begin
                    state_n = IDLE;
                    fault_n = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (estop) begin
            state_n  = ESTOP;
            floor_n  = floor;
            dir_n    = dir_up;
            clr      = '0;
            absorb   = '0;
            motor_n  = 1'b0;
            door_n   = 1'b0;
            arrive_n = 1'b0;
            fault_n  = 1'b1;
            move_n   = '0;
            dwell_n  = '0;
`ifdef LIFT_PARK_EN
            park_n     = '0;
            park_start = 1'b0;
`endif
        end

        pending_n = (pending | (call_req & ~absorb)) & ~clr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            floor     <= '0;
            pending   <= '0;
            motor_on  <= 1'b0;
            dir_up    <= 1'b1;
            door_open <= 1'b0;
            arrive    <= 1'b0;
            fault     <= 1'b0;
            move_cnt  <= '0;
            dwell     <= '0;
        end else begin
            state     <= state_n;
            floor     <= floor_n;
            pending   <= pending_n;
            motor_on  <= motor_n;
            dir_up    <= dir_n;
            door_open <= door_n;
            arrive    <= arrive_n;
            fault     <= fault_n;
            move_cnt  <= move_n;
            dwell     <= dwell_n;
        end
    end

`ifdef LIFT_PARK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            park_cnt <= '0;
            parking  <= 1'b0;
        end else begin
            park_cnt <= park_n;
            parking  <= park_start || (parking && state_n == MOVE_DN && pending == '0);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lift_ctrl_n.sv
`default_nettype none
// Testbench for lift_ctrl_n: directed calls, with a scoreboard of expected
// arrive / door-close / fault / park-halt events checked by a separate monitor.
module tb_lift_ctrl_n;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] call_req;
    logic       door_block;
    logic       estop;
    logic [1:0] floor;
    logic [3:0] pending;
    logic       motor_on, dir_up, door_open, arrive, fault;

    always #5 clk = ~clk;

    lift_ctrl_n #(
        .FLOORS      (4),
        .MOVE_CYCLES (4),
        .DOOR_CYCLES (8),
        .PARK_CYCLES (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .call_req   (call_req),
        .door_block (door_block),
        .estop      (estop),
        .floor      (floor),
        .pending    (pending),
        .motor_on   (motor_on),
        .dir_up     (dir_up),
        .door_open  (door_open),
        .arrive     (arrive),
        .fault      (fault)
    );

    localparam logic [1:0] EV_ARRIVE = 2'd0;
    localparam logic [1:0] EV_CLOSE  = 2'd1;
    localparam logic [1:0] EV_FAULT  = 2'd2;
    localparam logic [1:0] EV_HALT   = 2'd3;

    typedef struct {
        logic [1:0] kind;
        int         flr;
        int         cyc;
    } ev_t;

    ev_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic mon_en = 1'b0;
    logic prev_door = 1'b0, prev_motor = 1'b0, prev_fault = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input logic [1:0] k);
        case (k)
            EV_ARRIVE: return "arrive";
            EV_CLOSE:  return "door_close";
            EV_FAULT:  return "fault";
            default:   return "park_halt";
        endcase
    endfunction

    task automatic push_ev(input logic [1:0] k, input int f, input int c);
        ev_t e;
        e.kind = k;
        e.flr  = f;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic handle(input logic [1:0] k);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event_%s: got floor=%0d cyc=%0d, required no event", kname(k), floor, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.flr != int'(floor) || e.cyc != cyc) begin
                errors++;
                $display("FAIL event_%s: got %s floor=%0d cyc=%0d, required %s floor=%0d cyc=%0d",
                         kname(e.kind), kname(k), floor, cyc, kname(e.kind), e.flr, e.cyc);
            end
        end
    endtask

    // Monitor: turns DUT output transitions into events and checks them in order.
    always @(negedge clk) begin
        if (mon_en) begin
            if (arrive) handle(EV_ARRIVE);
            if (prev_door && !door_open) handle(EV_CLOSE);
            if (!prev_fault && fault) handle(EV_FAULT);
            if (prev_motor && !motor_on && !door_open && !fault) handle(EV_HALT);
        end
        prev_door  = door_open;
        prev_motor = motor_on;
        prev_fault = fault;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic goto(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding events, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        rst        = 1'b1;
        call_req   = '0;
        door_block = 1'b0;
        estop      = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_floor", floor, 0);
        chk("rst_pending", pending, 0);
        chk("rst_dir_up", dir_up, 1);
        chk("rst_outputs", {motor_on, door_open, arrive, fault}, 0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Single call at floor 2 from reset.
        k = cyc;
        call_req = 4'b0100;
        push_ev(EV_ARRIVE, 2, k + 10);
        push_ev(EV_CLOSE, 2, k + 18);
        goto(k + 1);
        call_req = '0;
        chk("pend_latch", pending, 4'b0100);
        chk("motor_wait", motor_on, 0);
        goto(k + 2);
        chk("motor_start", motor_on, 1);
        drain(100);
        chk("pend_served", pending, 0);

        // Back to floor 0 (reversal downwards).
        k = cyc;
        call_req = 4'b0001;
        push_ev(EV_ARRIVE, 0, k + 10);
        push_ev(EV_CLOSE, 0, k + 18);
        goto(k + 1);
        call_req = '0;
        goto(k + 3);
        chk("rev_down_dir", dir_up, 0);
        drain(100);

        // Calls at 1 and 3 together: stop at 1, continue up to 3.
        k = cyc;
        call_req = 4'b1010;
        push_ev(EV_ARRIVE, 1, k + 6);
        push_ev(EV_CLOSE, 1, k + 14);
        push_ev(EV_ARRIVE, 3, k + 23);
        push_ev(EV_CLOSE, 3, k + 31);
        goto(k + 1);
        call_req = '0;
        chk("pend_two", pending, 4'b1010);
        goto(k + 16);
        chk("continue_dir", dir_up, 1);
        chk("continue_motor", motor_on, 1);
        drain(100);

        // Down to 1, then up to 3 with a call at 0 arriving mid-travel.
        k = cyc;
        call_req = 4'b0010;
        push_ev(EV_ARRIVE, 1, k + 10);
        push_ev(EV_CLOSE, 1, k + 18);
        goto(k + 1);
        call_req = '0;
        drain(100);
        k = cyc;
        call_req = 4'b1000;
        push_ev(EV_ARRIVE, 3, k + 10);
        push_ev(EV_CLOSE, 3, k + 18);
        push_ev(EV_ARRIVE, 0, k + 31);
        push_ev(EV_CLOSE, 0, k + 39);
        goto(k + 1);
        call_req = '0;
        goto(k + 4);
        call_req = 4'b0001;
        goto(k + 5);
        call_req = '0;
        goto(k + 7);
        chk("pass_floor2", floor, 2);
        chk("pass_motor", motor_on, 1);
        goto(k + 20);
        chk("reverse_after3", dir_up, 0);
        drain(100);

        // Door at floor 2: door_block for 5 cycles, then an absorbed call.
        k = cyc;
        call_req = 4'b0100;
        push_ev(EV_ARRIVE, 2, k + 10);
        push_ev(EV_CLOSE, 2, k + 29);
        goto(k + 1);
        call_req = '0;
        goto(k + 12);
        door_block = 1'b1;
        goto(k + 17);
        door_block = 1'b0;
        goto(k + 20);
        call_req = 4'b0100;
        goto(k + 21);
        call_req = '0;
        chk("absorbed_call", pending, 0);
        goto(k + 26);
        chk("door_reloaded", door_open, 1);
        drain(100);

        // Down to 1, then estop during the move from 1 towards 2.
        k = cyc;
        call_req = 4'b0010;
        push_ev(EV_ARRIVE, 1, k + 6);
        push_ev(EV_CLOSE, 1, k + 14);
        goto(k + 1);
        call_req = '0;
        drain(100);
        k = cyc;
        call_req = 4'b1000;
        push_ev(EV_FAULT, 1, k + 4);
        push_ev(EV_ARRIVE, 3, k + 18);
        push_ev(EV_CLOSE, 3, k + 26);
        push_ev(EV_ARRIVE, 0, k + 39);
        push_ev(EV_CLOSE, 0, k + 47);
        goto(k + 1);
        call_req = '0;
        goto(k + 3);
        estop = 1'b1;
        goto(k + 4);
        chk("estop_fault", fault, 1);
        chk("estop_motor", motor_on, 0);
        chk("estop_floor", floor, 1);
        goto(k + 5);
        call_req = 4'b0001;
        goto(k + 6);
        call_req = '0;
        chk("estop_latch", pending, 4'b1001);
        goto(k + 8);
        estop = 1'b0;
        chk("estop_hold_floor", floor, 1);
        goto(k + 9);
        chk("estop_release", fault, 0);
        goto(k + 10);
        chk("restart_motor", motor_on, 1);
        goto(k + 13);
        chk("full_move", floor, 1);
        drain(150);

        // Up to 3, then sit idle with nothing pending.
        k = cyc;
        call_req = 4'b1000;
        push_ev(EV_ARRIVE, 3, k + 14);
        push_ev(EV_CLOSE, 3, k + 22);
`ifdef LIFT_PARK_EN
        push_ev(EV_HALT, 0, k + 66);
`endif
        goto(k + 1);
        call_req = '0;
`ifdef LIFT_PARK_EN
        goto(k + 53);
        chk("park_wait", motor_on, 0);
        goto(k + 54);
        chk("park_start", motor_on, 1);
        chk("park_dir", dir_up, 0);
        drain(150);
        chk("park_floor", floor, 0);
        chk("park_door", door_open, 0);
`else
        drain(100);
        goto(k + 80);
        chk("stay_floor", floor, 3);
        chk("stay_motor", motor_on, 0);
`endif

        // Reset in the middle of operation clears pending immediately.
        k = cyc;
        call_req = 4'b0010;
        goto(k + 1);
        call_req = '0;
        chk("pre_rst_pending", pending, 4'b0010);
        goto(k + 2);
        mon_en = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_pending", pending, 0);
        chk("mid_rst_floor", floor, 0);
        chk("mid_rst_motor", motor_on, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lift_ctrl_n.md
# lift_ctrl_n

Parametrised N-floor lift controller: the next-generation successor to the fixed-state lift benchmark FSMs. It latches hall/car calls per floor, schedules travel with a collective (SCAN) policy, times floor-to-floor motion and door dwell internally, and supports an emergency stop. It is a standalone FSM benchmark in the small-FSM suite and is driven directly by testbench stimulus.

## Interface
- FLOORS, 4, number of floors (2..16); floor index 0 is the bottom floor.
- MOVE_CYCLES, 4, clock cycles to travel one floor (≥1).
- DOOR_CYCLES, 8, clock cycles the door stays open (≥1).
- PARK_CYCLES, 32, idle cycles before parking (used only with LIFT_PARK_EN).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- call_req  in  FLOORS  one bit per floor; level-sampled every cycle and latched into pending.
- door_block  in  1  door obstruction; restarts the dwell timer while the door is open.
- estop  in  1  emergency stop; level-sensitive.
- floor  out  $clog2(FLOORS)  current floor index.
- pending  out  FLOORS  latched, unserviced requests.
- motor_on  out  1  car moving.
- dir_up  out  1  travel or scan direction is up.
- door_open  out  1  door open.
- arrive  out  1  one-cycle pulse when the car stops at a floor to service it.
- fault  out  1  high while in ESTOP.

## Operation
- States: IDLE, MOVE_UP, MOVE_DN, DOOR, ESTOP. All outputs are registered.
- Reset: state IDLE, floor 0, pending 0, dir_up 1, all other outputs 0, timers 0.
- Request latch: pending[i] is set when call_req[i] is 1. It is cleared only when the car services floor i. If a set and a clear hit the same bit in one cycle, the clear wins.
- IDLE:
  - If pending[floor] is set: go to DOOR, clear it, pulse arrive.
  - Otherwise, if a request exists in direction dir_up: move that way.
  - Otherwise, if a request exists in the opposite direction: flip dir_up and move.
  - Otherwise: stay in IDLE.
- MOVE_UP / MOVE_DN:
  - motor_on is 1. A move counter counts MOVE_CYCLES.
  - On terminal count, floor increments or decrements.
  - If pending at the new floor is set: go to DOOR, clear it, pulse arrive.
  - Otherwise, if requests remain ahead: continue. If none remain: go to IDLE.
  - floor never leaves 0..FLOORS-1. A move is never started past the end floors.
- DOOR:
  - door_open is 1. The dwell timer is loaded with DOOR_CYCLES.
  - door_block, or a new call_req at the current floor, reloads the timer. That call is absorbed and never lands in pending.
  - At timer expiry, go to IDLE. Scheduling then resumes with the same dir_up.
- ESTOP:
  - Entered from any state the cycle after estop is sampled high.
  - motor_on, door_open, and arrive are 0; fault is 1.
  - A partial move is discarded (move counter cleared) and floor is held. pending keeps latching.
  - When estop is sampled low, go to IDLE.
- Reset mid-operation clears everything immediately, including pending.

## Timing
- call_req to pending: 1 cycle.
- IDLE with a request at another floor: motor_on rises 1 cycle later.
- Floor-to-floor: exactly MOVE_CYCLES cycles per floor.
- Door open duration: exactly DOOR_CYCLES cycles after the last reload.
- arrive coincides with the first door_open cycle.
- estop takes priority over every other event in the same cycle.

## Configuration
- LIFT_PARK_EN defined:
  - A counter runs while the FSM is in IDLE with pending == 0 and floor != 0.
  - After PARK_CYCLES cycles, the car moves down to floor 0 and returns to IDLE without opening the door or pulsing arrive.
  - Any new request cancels parking. Normal scheduling resumes from the current floor.
- LIFT_PARK_EN undefined: no park counter is present, and the car stays at its last floor indefinitely.

## Test plan
- Reset, then a call_req[2] pulse (defaults): pending=4'b0100 after 1 cycle; floor reaches 2 after 8 motor cycles; arrive pulses; door_open high for 8 cycles; pending=0.
- Car at 0 with calls at 1 and 3 in one cycle: stops at 1 (door 8 cycles), then continues up to 3 with no reversal.
- Car moving up from 1 to 3; a call at 0 arrives mid-travel: services 3 first, then reverses with dir_up=0 and services 0.
- Door open at floor 2; door_block held 5 cycles mid-dwell: door closes 8 cycles after door_block falls.
- estop asserted mid-move between 1 and 2: fault=1, motor_on=0, floor stays 1. After release, the move restarts and takes a full MOVE_CYCLES.
- With LIFT_PARK_EN and PARK_CYCLES=32: idle at floor 3 with no requests; after 32 cycles the car descends to 0, arrive stays 0, door_open stays 0.
